// File: rtl/mmc_trig_sequencer_pkg.sv
// Shared constants for the MMC trigger sequencer: compare opcodes, config
// field offsets, packet field offsets and FSM state encodings.
package mmc_trig_sequencer_pkg;

  localparam logic [1:0] CMP_OP_EQ = 2'b00;
  localparam logic [1:0] CMP_OP_NE = 2'b01;
  localparam logic [1:0] CMP_OP_LT = 2'b10;
  localparam logic [1:0] CMP_OP_GT = 2'b11;

  localparam int CFG_DATA_LSB    = 32;
  localparam int CFG_CMD_LSB     = 26;
  localparam int CFG_TX_BIT      = 25;
  localparam int CFG_OP_LSB      = 23;
  localparam int CFG_DATA_EN_BIT = 2;
  localparam int CFG_CMD_EN_BIT  = 1;
  localparam int CFG_TX_EN_BIT   = 0;

  localparam int AUX_TMO_LSB = 16;
  localparam int AUX_REP_LSB = 0;

  localparam int PKT_TX_BIT  = 46;
  localparam int PKT_CMD_LSB = 40;
  localparam int PKT_ARG_LSB = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRE  = 2'd2;

endpackage

// File: rtl/mmc_trig_sequencer_cmp.sv
// mmc_stage_cmp: combinational match of one compare slot against a decoded
// MMC command packet.
module mmc_stage_cmp
  import mmc_trig_sequencer_pkg::*;
(
  input  logic [63:0] cfg,
  input  logic [47:0] packet,
  output logic        match
);

  logic [31:0] data;
  logic [31:0] arg;
  logic [5:0]  cfg_cmd;
  logic [5:0]  pkt_cmd;
  logic [1:0]  op;
  logic        data_ok;
  logic        unused_bits;

  assign data    = cfg[CFG_DATA_LSB +: 32];
  assign cfg_cmd = cfg[CFG_CMD_LSB +: 6];
  assign op      = cfg[CFG_OP_LSB +: 2];
  assign arg     = packet[PKT_ARG_LSB +: 32];
  assign pkt_cmd = packet[PKT_CMD_LSB +: 6];

  // Argument compares are unsigned.
  always_comb begin
    data_ok = 1'b0;
    case (op)
      CMP_OP_EQ: data_ok = (arg == data);
      CMP_OP_NE: data_ok = (arg != data);
      CMP_OP_LT: data_ok = (arg < data);
      CMP_OP_GT: data_ok = (arg > data);
      default:   data_ok = 1'b0;
    endcase
  end

  assign match = (data_ok || !cfg[CFG_DATA_EN_BIT])
              && ((cfg_cmd == pkt_cmd) || !cfg[CFG_CMD_EN_BIT])
              && ((cfg[CFG_TX_BIT] == packet[PKT_TX_BIT]) || !cfg[CFG_TX_EN_BIT]);

  assign unused_bits = ^{cfg[22:3], packet[47], packet[7:0]};

endmodule

// File: rtl/mmc_trig_sequencer.sv
// Multi-stage MMC command trigger sequencer. Define MMCTRIG_SEQ_TIMEOUT_EN to
// build the per-stage inter-stage timeout; otherwise stages wait indefinitely.
module mmc_trig_sequencer
  import mmc_trig_sequencer_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int PULSE_CYCLES = 127
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          cfg_wr,
  input  logic [$clog2(NUM_STAGES)-1:0] cfg_stage,
  input  logic [63:0]                   cfg_data,
  input  logic [31:0]                   cfg_aux,
  input  logic [$clog2(NUM_STAGES)-1:0] num_stages,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          rearm,
  input  logic [47:0]                   msg_packet,
  input  logic                          msg_valid,
  output logic                          trig_out,
  output logic                          busy,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic [7:0]                    fire_count
);

  localparam int         IW         = $clog2(NUM_STAGES);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

  logic [63:0] slot_cfg [NUM_STAGES];
  logic [7:0]  slot_rep [NUM_STAGES];
  logic [1:0]  state;
  logic [7:0]  rep_cnt;
  logic [7:0]  pulse_cnt;
  logic [7:0]  eff_rep;
  logic        match;
  logic        hit_match;
  logic        rep_done;
  logic        tmo_hit;
  logic        unused_aux;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        slot_cfg[i] <= '0;
        slot_rep[i] <= '0;
      end
    end else if (cfg_wr) begin
      slot_cfg[cfg_stage] <= cfg_data;
      slot_rep[cfg_stage] <= cfg_aux[AUX_REP_LSB +: 8];
    end
  end

  mmc_stage_cmp u_cmp (
    .cfg    (slot_cfg[stage_idx]),
    .packet (msg_packet),
    .match  (match)
  );

  // A repeat count of zero behaves like one.
  assign eff_rep   = (slot_rep[stage_idx] == 8'd0) ? 8'd1 : slot_rep[stage_idx];
  assign rep_done  = ({1'b0, rep_cnt} + 9'd1) >= {1'b0, eff_rep};
  assign hit_match = msg_valid && match;
  assign unused_aux = ^cfg_aux[15:8];

`ifdef MMCTRIG_SEQ_TIMEOUT_EN
  logic [15:0]          slot_tmo [NUM_STAGES];
  logic [CNT_WIDTH-1:0] tmo_cnt;
  logic [CNT_WIDTH-1:0] tmo_next;
  logic [CNT_WIDTH-1:0] tmo_limit;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_STAGES; i++) slot_tmo[i] <= '0;
    end else if (cfg_wr) begin
      slot_tmo[cfg_stage] <= cfg_aux[AUX_TMO_LSB +: 16];
    end
  end

  // tmo_next is the number of cycles spent in the stage once this edge passes.
  assign tmo_next  = (&tmo_cnt) ? tmo_cnt : tmo_cnt + CNT_WIDTH'(1);
  assign tmo_limit = CNT_WIDTH'(slot_tmo[stage_idx]);
  assign tmo_hit   = (state == ST_ARMED) && (stage_idx != '0)
                  && (tmo_limit != '0) && (tmo_next >= tmo_limit);

  always_ff @(posedge clk) begin
    if (reset_i || abort || arm || state != ST_ARMED || stage_idx == '0
        || (hit_match && rep_done) || (tmo_hit && !hit_match))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_next;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_aux[31:16];
  assign tmo_hit    = 1'b0;
`endif

  // Priority inside ARMED: abort, then arm, then a match, then a timeout.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      stage_idx  <= '0;
      rep_cnt    <= '0;
      pulse_cnt  <= '0;
      fire_count <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      stage_idx <= '0;
      rep_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state     <= ST_ARMED;
            stage_idx <= '0;
            rep_cnt   <= '0;
          end
        end
        ST_ARMED: begin
          if (arm) begin
            stage_idx <= '0;
            rep_cnt   <= '0;
          end else if (hit_match) begin
            if (!rep_done) begin
              rep_cnt <= rep_cnt + 8'd1;
            end else if (stage_idx >= num_stages) begin
              state      <= ST_FIRE;
              stage_idx  <= '0;
              rep_cnt    <= '0;
              pulse_cnt  <= PULSE_LAST;
              fire_count <= fire_count + 8'd1;
            end else begin
              stage_idx <= stage_idx + IW'(1);
              rep_cnt   <= '0;
            end
          end else if (tmo_hit) begin
            stage_idx <= '0;
            rep_cnt   <= '0;
          end
        end
        ST_FIRE: begin
          if (pulse_cnt == 8'd0)
            state <= rearm ? ST_ARMED : ST_IDLE;
          else
            pulse_cnt <= pulse_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign trig_out = (state == ST_FIRE);
  assign busy     = (state == ST_ARMED) || (state == ST_FIRE);

endmodule

// File: tb/tb_mmc_trig_sequencer.sv
// Self-checking bench for mmc_trig_sequencer: a cycle-counting reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mmc_trig_sequencer;

`ifdef MMCTRIG_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int NS = 4;
  localparam int P  = 127;
  localparam logic [1:0] OP_EQ = 2'b00;
  localparam logic [1:0] OP_LT = 2'b10;

  logic        clk;
  logic        reset_i;
  logic        cfg_wr;
  logic [1:0]  cfg_stage;
  logic [63:0] cfg_data;
  logic [31:0] cfg_aux;
  logic [1:0]  num_stages;
  logic        arm;
  logic        abort;
  logic        rearm;
  logic [47:0] msg_packet;
  logic        msg_valid;
  logic        trig_out;
  logic        busy;
  logic [1:0]  stage_idx;
  logic [7:0]  fire_count;

  int compared   = 0;
  int mismatched = 0;

  mmc_trig_sequencer #(.NUM_STAGES(NS), .CNT_WIDTH(16), .PULSE_CYCLES(P)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .cfg_wr     (cfg_wr),
    .cfg_stage  (cfg_stage),
    .cfg_data   (cfg_data),
    .cfg_aux    (cfg_aux),
    .num_stages (num_stages),
    .arm        (arm),
    .abort      (abort),
    .rearm      (rearm),
    .msg_packet (msg_packet),
    .msg_valid  (msg_valid),
    .trig_out   (trig_out),
    .busy       (busy),
    .stage_idx  (stage_idx),
    .fire_count (fire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: absolute cycle numbers for pulse end and stage entry.
  logic [63:0] m_cfg [NS];
  logic [7:0]  m_rep [NS];
  logic [15:0] m_tmo [NS];
  bit          m_armed, m_fire, model_ok;
  int          m_stage, m_hits, m_fires, m_fire_end, m_entry, m_need;
  int          cyc = 0;

  function automatic bit slot_matches(logic [63:0] c, logic [47:0] p);
    logic [31:0] a;
    logic [31:0] d;
    bit d_ok;
    a = p[39:8];
    d = c[63:32];
    case (c[24:23])
      2'b00:   d_ok = (a == d);
      2'b01:   d_ok = (a != d);
      2'b10:   d_ok = (a < d);
      default: d_ok = (a > d);
    endcase
    return (d_ok || !c[2]) && ((c[31:26] == p[45:40]) || !c[1]) && ((c[25] == p[46]) || !c[0]);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset_i) begin
      for (int i = 0; i < NS; i++) begin
        m_cfg[i] = '0; m_rep[i] = '0; m_tmo[i] = '0;
      end
      m_armed = 0; m_fire = 0; m_stage = 0; m_hits = 0; m_fires = 0;
      model_ok = 1;
    end else begin
      if (abort) begin
        m_armed = 0; m_fire = 0; m_stage = 0; m_hits = 0;
      end else if (m_fire) begin
        if (cyc >= m_fire_end) begin
          m_fire = 0;
          if (rearm) begin m_armed = 1; m_stage = 0; m_hits = 0; end
        end
      end else if (!m_armed) begin
        if (arm) begin m_armed = 1; m_stage = 0; m_hits = 0; end
      end else if (arm) begin
        m_stage = 0; m_hits = 0;
      end else if (msg_valid && slot_matches(m_cfg[m_stage], msg_packet)) begin
        m_hits++;
        m_need = (m_rep[m_stage] == 0) ? 1 : int'(m_rep[m_stage]);
        if (m_hits >= m_need) begin
          m_hits = 0;
          if (m_stage >= int'(num_stages)) begin
            m_armed = 0; m_fire = 1; m_fire_end = cyc + P; m_fires++; m_stage = 0;
          end else begin
            m_stage++; m_entry = cyc;
          end
        end
      end else if (TMO_EN && m_stage != 0 && m_tmo[m_stage] != 0
                   && (cyc - m_entry) >= int'(m_tmo[m_stage])) begin
        m_stage = 0; m_hits = 0;
      end
      if (cfg_wr) begin
        m_cfg[cfg_stage] = cfg_data;
        m_rep[cfg_stage] = cfg_aux[7:0];
        m_tmo[cfg_stage] = cfg_aux[31:16];
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      compared++;
      if ({trig_out, busy, stage_idx, fire_count} !==
          {m_fire, (m_armed || m_fire), 2'(m_stage), 8'(m_fires)}) begin
        mismatched++;
        $display("[TB] FAIL cycle_outputs @%0t: got trig=%b busy=%b stage=%0d fc=%0d, expected trig=%b busy=%b stage=%0d fc=%0d",
                 $time, trig_out, busy, stage_idx, fire_count,
                 m_fire, (m_armed || m_fire), m_stage, m_fires[7:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_cfg(logic [31:0] d, logic [5:0] c, logic t,
                                         logic [1:0] op, logic den, logic cen, logic ten);
    return {d, c, t, op, 20'b0, den, cen, ten};
  endfunction

  function automatic logic [47:0] mk_pkt(logic t, logic [5:0] c, logic [31:0] a);
    return {1'b0, t, c, a, 8'h01};
  endfunction

  task automatic write_slot(logic [1:0] idx, logic [63:0] d, logic [15:0] tmo, logic [7:0] rep);
    cfg_stage = idx; cfg_data = d; cfg_aux = {tmo, 8'h00, rep}; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic send_msg(logic [47:0] p);
    msg_packet = p; msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic wait_pulse_end();
    for (int i = 0; i < 300; i++) begin
      if (!trig_out) break;
      step();
    end
    check_output("pulse_end", {31'b0, trig_out}, 32'd0);
  endtask

  task automatic check_idle(string name);
    check_output({name, "_trig"}, {31'b0, trig_out}, 32'd0);
    check_output({name, "_busy"}, {31'b0, busy}, 32'd0);
    check_output({name, "_stage"}, {30'b0, stage_idx}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int high;
    reset_i = 1'b1; cfg_wr = 1'b0; cfg_stage = '0; cfg_data = '0; cfg_aux = '0;
    num_stages = 2'd0; arm = 1'b0; abort = 1'b0; rearm = 1'b0;
    msg_packet = '0; msg_valid = 1'b0;
    step(); step();
    reset_i = 1'b0;
    check_idle("reset");
    check_output("reset_fc", {24'b0, fire_count}, 32'd0);

    $display("[TB] single stage CMD17");
    write_slot(2'd0, mk_cfg(32'h0, 6'd17, 1'b0, OP_EQ, 1'b0, 1'b1, 1'b0), 16'd0, 8'd0);
    pulse_arm();
    check_output("arm_busy", {31'b0, busy}, 32'd1);
    send_msg(mk_pkt(1'b0, 6'd13, 32'h0));
    check_output("cmd13_no_trig", {31'b0, trig_out}, 32'd0);
    send_msg(mk_pkt(1'b0, 6'd17, 32'h0));
    check_output("cmd17_trig", {31'b0, trig_out}, 32'd1);
    high = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!trig_out) break;
      high++;
    end
    check_output("pulse_width", high, 32'd127);
    check_output("t1_busy_after", {31'b0, busy}, 32'd0);
    check_output("t1_fc", {24'b0, fire_count}, 32'd1);

    $display("[TB] two stages with repeat");
    num_stages = 2'd1;
    write_slot(2'd0, mk_cfg(32'h0, 6'd18, 1'b0, OP_EQ, 1'b0, 1'b1, 1'b0), 16'd0, 8'd0);
    write_slot(2'd1, mk_cfg(32'h1000, 6'd0, 1'b0, OP_LT, 1'b1, 1'b0, 1'b0), 16'd0, 8'd3);
    pulse_arm();
    send_msg(mk_pkt(1'b0, 6'd18, 32'h5000));
    check_output("t2_stage1", {30'b0, stage_idx}, 32'd1);
    send_msg(mk_pkt(1'b0, 6'd0, 32'h2000));
    check_output("t2_hi_arg", {31'b0, trig_out}, 32'd0);
    send_msg(mk_pkt(1'b0, 6'd0, 32'h10));
    send_msg(mk_pkt(1'b0, 6'd0, 32'h20));
    check_output("t2_second_low", {31'b0, trig_out}, 32'd0);
    send_msg(mk_pkt(1'b0, 6'd0, 32'h30));
    check_output("t2_third_low", {31'b0, trig_out}, 32'd1);
    wait_pulse_end();

    $display("[TB] inter-stage timeout");
    write_slot(2'd1, mk_cfg(32'h1000, 6'd0, 1'b0, OP_LT, 1'b1, 1'b0, 1'b0), 16'd50, 8'd1);
    pulse_arm();
    send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
    repeat (49) step();
    check_output("t3_stage_49", {30'b0, stage_idx}, 32'd1);
    step();
    check_output("t3_stage_50", {30'b0, stage_idx}, TMO_EN ? 32'd0 : 32'd1);
    repeat (10) step();
    send_msg(mk_pkt(1'b0, 6'd13, 32'h10));
    check_output("t3_late_match", {31'b0, trig_out}, TMO_EN ? 32'd0 : 32'd1);
    wait_pulse_end();
    pulse_abort();

    $display("[TB] match and timeout together");
    pulse_arm();
    send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
    repeat (49) step();
    send_msg(mk_pkt(1'b0, 6'd13, 32'h10));
    check_output("t4_fire", {31'b0, trig_out}, 32'd1);
    wait_pulse_end();

    $display("[TB] rearm");
    rearm = 1'b1;
    pulse_arm();
    for (int k = 0; k < 3; k++) begin
      send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
      send_msg(mk_pkt(1'b0, 6'd13, 32'h10));
      check_output("t5_fire", {31'b0, trig_out}, 32'd1);
      repeat (3) step();
      send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
      wait_pulse_end();
      check_output("t5_stage_after", {30'b0, stage_idx}, 32'd0);
      check_output("t5_busy_after", {31'b0, busy}, 32'd1);
    end
    rearm = 1'b0;
    check_output("t5_fc", {24'b0, fire_count}, TMO_EN ? 32'd6 : 32'd7);
    pulse_abort();

    $display("[TB] abort");
    pulse_arm();
    send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
    check_output("t6_stage1", {30'b0, stage_idx}, 32'd1);
    pulse_abort();
    check_idle("t6_abort_stage");
    pulse_arm();
    send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
    send_msg(mk_pkt(1'b0, 6'd13, 32'h10));
    repeat (10) step();
    pulse_abort();
    check_idle("t6_abort_fire");

    $display("[TB] reset mid-pulse");
    pulse_arm();
    send_msg(mk_pkt(1'b0, 6'd18, 32'h0));
    send_msg(mk_pkt(1'b0, 6'd13, 32'h10));
    repeat (5) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_idle("t7_reset");
    check_output("t7_fc", {24'b0, fire_count}, 32'd0);
    num_stages = 2'd0;
    pulse_arm();
    send_msg(mk_pkt(1'b1, 6'd5, 32'hABCD));
    check_output("t7_any_fires", {31'b0, trig_out}, 32'd1);
    check_output("t7_fc_after", {24'b0, fire_count}, 32'd1);
    wait_pulse_end();

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmc_trig_sequencer.md
Name: mmc_trig_sequencer

Overview:
- Multi-stage trigger controller for the MMC command-line trigger path.
- Drives 1..NUM_STAGES compare slots, each in the CFG-register compare format, against decoded MMC command packets.
- Fires the stretched trig_out only after the stages match in order, each with a repeat count and an optional inter-stage timeout.
- Sits between mmc_msg_capture (packets already resynchronised to clk) and the scope trigger mux; written by the register block.

Parameters:
- NUM_STAGES, 4: number of compare slots, power of two, 2..8.
- CNT_WIDTH, 16: width of the timeout counter.
- PULSE_CYCLES, 127: trig_out high time in clk cycles, 1..255.

Ports:
- clk  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- cfg_wr  in  1  one-cycle strobe; latches cfg_data and cfg_aux into slot cfg_stage.
- cfg_stage  in  $clog2(NUM_STAGES)  slot index for the write.
- cfg_data  in  64  compare word:
  - [63:32] data; [31:26] cmd; [25] transmission bit; [24:23] op (00 EQ, 01 NE, 10 LT, 11 GT).
  - [2] data enable; [1] cmd enable; [0] transmission enable.
- cfg_aux  in  32  [31:16] timeout cycles (0 = none); [7:0] repeat count (0 treated as 1).
- num_stages  in  $clog2(NUM_STAGES)  active stages minus 1.
- arm  in  1  one-cycle start strobe.
- abort  in  1  one-cycle cancel strobe.
- rearm  in  1  level; re-arm automatically after a fire.
- msg_packet  in  48  decoded packet; [46] transmission bit, [45:40] cmd, [39:8] argument.
- msg_valid  in  1  one-cycle strobe; msg_packet valid this cycle.
- trig_out  out  1  trigger output.
- busy  out  1  high in ARMED or FIRE.
- stage_idx  out  $clog2(NUM_STAGES)  current stage.
- fire_count  out  8  fires since reset; wraps 255 -> 0.

Behaviour:
- Reset: all slot configs 0; state IDLE; trig_out, busy, stage_idx, fire_count all 0.
- Slot match condition: (data-op result OR !data_en) AND (cmd equal OR !cmd_en) AND (transmission bit equal OR !tx_en).
  - Compares are unsigned, on msg_packet[39:8].
  - All enables clear means every msg_valid matches.
- Slot writes are accepted in any state. A write to the current slot takes effect from the next msg_valid; the repeat counter is not reset.
- IDLE -> ARMED on arm: stage_idx = 0, rep_cnt = 0, tmo_cnt = 0, busy = 1 on the next cycle.
- ARMED, on msg_valid with a slot match:
  - rep_cnt+1 < repeat: increment rep_cnt only.
  - Repeat reached, stage_idx < num_stages: stage_idx+1; rep_cnt and tmo_cnt cleared.
  - Repeat reached, stage_idx == num_stages: go to FIRE.
- ARMED, msg_valid without a match: no state change. Non-matching packets between stages are allowed.
- Timeout:
  - tmo_cnt counts clk cycles while stage_idx > 0. It saturates at all-ones; it does not wrap.
  - When tmo_cnt reaches the current slot's timeout (non-zero): stage_idx = 0, rep_cnt = 0; the block stays ARMED.
  - A match and a timeout in the same cycle: the match wins.
- FIRE:
  - trig_out rises in the same cycle FIRE is entered, i.e. 1 clk after the final matching msg_valid.
  - trig_out stays high exactly PULSE_CYCLES cycles; fire_count increments on entry.
  - At the end: rearm = 1 -> ARMED with stage 0; otherwise -> IDLE.
  - msg_valid during FIRE is ignored, and does not count toward the re-armed sequence.
- abort in any state: IDLE next cycle; trig_out = 0, busy = 0, stage_idx = 0. abort wins over a simultaneous arm or match.
- arm while ARMED restarts the sequence at stage 0. arm while FIRE is ignored.
- reset_i in mid-pulse: trig_out = 0 next cycle; all slot configs cleared.
- num_stages changed while ARMED:
  - If stage_idx > new num_stages, the next matching stage_idx slot fires.
  - No out-of-range slot access is permitted; index compares use >=.

Optional Feature:
- MMCTRIG_SEQ_TIMEOUT_EN
- Defined: timeout logic as above.
- Undefined: no tmo_cnt register is synthesised and cfg_aux[31:16] is ignored. Sequences wait indefinitely; only abort or reset returns the block to stage 0. Ports are unchanged.

Decomposition:
- Shared package/include holds:
  - CMP_OP_EQ/NE/LT/GT codes.
  - cfg_data bit-field offsets, cfg_aux field offsets.
  - FSM state encodings IDLE/ARMED/FIRE.
- One sub-module, mmc_stage_cmp: combinational slot-match given a 64-bit config and msg_packet.
  - Instantiated once; it is fed the slot selected by stage_idx via a mux.

Test Plan:
- 1 stage, cmd-only CMD17 (cfg_data[31:26]=17, [1]=1), arm, send CMD13 then CMD17 -> no trigger on CMD13; trig_out rises 1 clk after the CMD17 msg_valid, high 127 cycles; fire_count = 1; busy low after.
- 2 stages (CMD18, then arg LT 0x1000, repeat 3), send CMD18, arg 0x2000, 0x10, 0x20, 0x30 -> fire on the third low-arg packet only; stage_idx 0->1.
- Timeout: stage-1 timeout 50, send CMD18, wait 60 cycles, send a matching packet -> no fire, stage_idx back to 0 at cycle 50. Repeat without the macro -> fires.
- Match and timeout in the same cycle at the final stage -> fire occurs.
- rearm = 1, 3 matching sequences -> 3 pulses, fire_count = 3. A msg_valid during a pulse does not advance the stage.
- abort during stage 1 and again during the FIRE pulse -> trig_out 0 next cycle, IDLE, stage_idx 0. reset_i mid-pulse -> all outputs 0, config cleared (a subsequent arm with all enables 0 fires on any packet).
